// File: rtl/gaussian_smoother.sv
// 3x3 Gaussian smoother over a raster pixel stream.
// It uses two line buffers, a 3x3 window and a two-stage sum/round pipeline.
module gaussian_smoother #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ROUND  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eof
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned SW = DATA_W + 4;

  logic [CW-1:0]     col, pc;
  logic [RW-1:0]     row, pr;
  logic              accept;
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] win [3][3];
  logic              v0, e0, v1, e1;
  logic [SW-1:0]     sum_c, sum_q, res_c;

  assign in_ready = enb;
  assign accept   = in_valid && enb && !reset;

  // A start-of-frame pixel is always placed at (0,0).
  assign pc = in_sof ? '0 : col;
  assign pr = in_sof ? '0 : row;

  // Position of the next accepted pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (pc == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (pr == RW'(IMG_H - 1)) ? '0 : pr + RW'(1);
      end else begin
        col <= pc + CW'(1);
        row <= pr;
      end
    end
  end

  // Line buffers hold rows r-1 and r-2.
  // The window holds rows r-2..r (win[0] is the oldest) and columns c-2..c.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[pc] <= in_data;
      lb2[pc] <= lb1[pc];
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb2[pc];
      win[1][2] <= lb1[pc];
      win[2][2] <= in_data;
    end
  end

  // The window is valid only once two full rows and two columns of this frame sit behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      v0 <= 1'b0;
      e0 <= 1'b0;
      v1 <= 1'b0;
      e1 <= 1'b0;
    end else if (enb) begin
      v0 <= accept && (pr >= RW'(2)) && (pc >= CW'(2));
      e0 <= accept && (pr == RW'(IMG_H - 1)) && (pc == CW'(IMG_W - 1));
      v1 <= v0;
      e1 <= e0;
    end
  end

  always_comb begin
    sum_c = SW'(win[0][0]) + (SW'(win[0][1]) << 1) + SW'(win[0][2])
          + (SW'(win[1][0]) << 1) + (SW'(win[1][1]) << 2) + (SW'(win[1][2]) << 1)
          + SW'(win[2][0]) + (SW'(win[2][1]) << 1) + SW'(win[2][2]);
  end

  always_ff @(posedge clk) begin
    if (enb && v0) sum_q <= sum_c;
  end

  // The maximum sum is 16*(2^DATA_W-1), so adding 8 cannot carry out of SW bits.
  assign res_c = (ROUND != 0) ? ((sum_q + SW'(8)) >> 4) : (sum_q >> 4);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eof   <= 1'b0;
    end else if (enb) begin
      out_valid <= v1;
      out_eof   <= v1 && e1;
      if (v1) out_data <= DATA_W'(res_c);
    end
  end

endmodule

// File: tb/tb_gaussian_smoother.sv
// Randomized bench for gaussian_smoother (4x4 frames) with rounding and truncating instances.
// A frame-array convolution model predicts every output cycle by cycle.
module tb_gaussian_smoother;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enb = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_sof = 1'b0;
  logic       rdy_r, rdy_t;
  logic       vld_r, vld_t, eof_r, eof_t;
  logic [7:0] dat_r, dat_t;

  always #5 clk = ~clk;

  gaussian_smoother #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .ROUND(1)) u_dut_rnd (
    .clk(clk), .reset(reset), .enb(enb), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .in_ready(rdy_r), .out_valid(vld_r), .out_data(dat_r), .out_eof(eof_r));

  gaussian_smoother #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .ROUND(0)) u_dut_trn (
    .clk(clk), .reset(reset), .enb(enb), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .in_ready(rdy_t), .out_valid(vld_t), .out_data(dat_t), .out_eof(eof_t));

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  int n_eof = 0;

  typedef struct {
    int cnt;
    int d1;
    int d0;
    bit eof;
  } pend_t;

  pend_t pend[$];
  int    img [H][W];
  int    mr = 0, mc = 0;
  int    exp_v = 0, exp_d1 = 0, exp_d0 = 0, exp_e = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: write the pixel into the frame and convolve when a full 3x3 neighbourhood exists.
  task automatic model_edge(input bit en, input bit v, input int d, input bit sof, input bit rst);
    int pr, pc, sum;
    pend_t it;
    if (rst) begin
      mr = 0; mc = 0;
      pend.delete();
      exp_v = 0; exp_d1 = 0; exp_d0 = 0; exp_e = 0;
    end else if (en) begin
      exp_v = 0;
      exp_e = 0;
      foreach (pend[i]) pend[i].cnt = pend[i].cnt - 1;
      if (pend.size() > 0 && pend[0].cnt == 0) begin
        it = pend.pop_front();
        exp_v = 1; exp_d1 = it.d1; exp_d0 = it.d0; exp_e = it.eof;
      end
      if (v) begin
        pr = sof ? 0 : mr;
        pc = sof ? 0 : mc;
        img[pr][pc] = d;
        if (pr >= 2 && pc >= 2) begin
          sum = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              sum += img[pr - 1 + dr][pc - 1 + dc] * (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc));
          it.cnt = 2;
          it.d1 = (sum + 8) / 16;
          it.d0 = sum / 16;
          it.eof = (pr == H - 1) && (pc == W - 1);
          pend.push_back(it);
        end
        if (pc == W - 1) begin
          mc = 0;
          mr = (pr == H - 1) ? 0 : pr + 1;
        end else begin
          mc = pc + 1;
          mr = pr;
        end
      end
    end
  endtask

  task automatic cycle(input bit en, input bit v, input int d, input bit sof, input bit rst);
    enb = en; in_valid = v; in_data = 8'(d); in_sof = sof; reset = rst;
    @(posedge clk);
    model_edge(en, v, d, sof, rst);
    #1;
    check_eq("rdy_r", int'(rdy_r), int'(en));
    check_eq("rdy_t", int'(rdy_t), int'(en));
    check_eq("vld_r", int'(vld_r), exp_v);
    check_eq("vld_t", int'(vld_t), exp_v);
    check_eq("dat_r", int'(dat_r), exp_d1);
    check_eq("dat_t", int'(dat_t), exp_d0);
    check_eq("eof_r", int'(eof_r), exp_e);
    check_eq("eof_t", int'(eof_t), exp_e);
    if (vld_r === 1'b1) n_out++;
    if (eof_r === 1'b1) n_eof++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Optional in_valid gaps and enb stalls, then one accepted pixel.
  task automatic send_px(input int d, input bit sof, input int gap_max, input int stall_pct);
    repeat ($urandom_range(0, gap_max)) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
    if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct)
      repeat ($urandom_range(1, 3)) cycle(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, d, sof, 1'b0);
  endtask

  // kind: 0 constant val, 1 impulse at (1,1), 2 random
  task automatic send_frame(input int kind, input int val, input int gap_max, input int stall_pct);
    int d;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case (kind)
          0:       d = val;
          1:       d = (r == 1 && c == 1) ? val : 0;
          default: d = int'($urandom_range(0, 255));
        endcase
        send_px(d, r == 0 && c == 0, gap_max, stall_pct);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 7, 1'b1, 1'b1);
    idle(2);

    // Constant frame, back-to-back pixels
    n_out = 0; n_eof = 0;
    send_frame(0, 100, 0, 0);
    idle(3);
    check_eq("const_outs", n_out, 4);
    check_eq("const_eofs", n_eof, 1);

    send_frame(1, 255, 0, 0);
    idle(3);
    send_frame(0, 255, 0, 0);
    idle(3);

    // Explicit stall: three enb=0 cycles mid-frame, then in_valid gaps of 1-2 cycles
    n_out = 0;
    for (int i = 0; i < W * H; i++) begin
      if (i == 11) repeat (3) cycle(1'b0, 1'b1, 9, 1'b0, 1'b0);
      if (i > 11) repeat (1 + (i % 2)) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, int'($urandom_range(0, 255)), i == 0, 1'b0);
    end
    idle(3);
    check_eq("stall_outs", n_out, 4);

    // Random frames with random gaps and stalls
    for (int f = 0; f < 6; f++) send_frame(2, 0, 2, 20);
    idle(4);

    // Reset mid-frame after 7 pixels, then a fresh constant frame
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 200, i == 0, 1'b0);
    cycle(1'b1, 1'b1, 50, 1'b0, 1'b1);
    n_out = 0; n_eof = 0;
    for (int i = 0; i < W * H; i++) cycle(1'b1, 1'b1, 100, 1'b0, 1'b0);
    idle(3);
    check_eq("rst_outs", n_out, 4);
    check_eq("rst_eofs", n_eof, 1);

    // Resync on the 6th pixel of a frame
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, int'($urandom_range(0, 255)), i == 0, 1'b0);
    n_out = 0; n_eof = 0;
    for (int i = 0; i < W * H; i++) cycle(1'b1, 1'b1, int'($urandom_range(0, 255)), i == 0, 1'b0);
    idle(3);
    check_eq("sync_outs", n_out, 4);
    check_eq("sync_eofs", n_eof, 1);

    // Reset while enb=0 must still clear the outputs
    send_frame(2, 0, 0, 0);
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gaussian_smoother.md
GAUSSIAN_SMOOTHER -- requirements
Module: gaussian_smoother

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk clocks the block, and reset is sampled only on the rising edge of clk.
REQ-002 Parameter DATA_W, default 8: pixel width in bits.
REQ-003 Parameter IMG_W, default 640: pixels per line; legal range is 3 or more.
REQ-004 Parameter IMG_H, default 480: lines per frame; legal range is 3 or more.
REQ-005 Parameter ROUND, default 1: 1 rounds half-up, 0 truncates.
REQ-006 Port clk  input  1  rising-edge clock for all state.
REQ-007 Port reset  input  1  synchronous active-high reset.
REQ-008 Port enb  input  1  global enable; 0 freezes all state.
REQ-009 Port in_valid  input  1  in_data carries a pixel this cycle.
REQ-010 Port in_data  input  DATA_W  unsigned pixel, raster order.
REQ-011 Port in_sof  input  1  qualified by in_valid; marks the pixel at (0,0).
REQ-012 Port in_ready  output  1  equals enb; a pixel is accepted when in_valid, in_ready and reset=0.
REQ-013 Port out_valid  output  1  out_data holds a smoothed pixel.
REQ-014 Port out_data  output  DATA_W  smoothed pixel.
REQ-015 Port out_eof  output  1  asserted together with the last output of a frame.

Function
REQ-016 The block SHALL keep a column counter col (0..IMG_W-1) and a row counter row (0..IMG_H-1) that give the position of the next accepted pixel.
REQ-017 On each accept, col SHALL increment; col=IMG_W-1 SHALL wrap col to 0 and increment row; (IMG_H-1, IMG_W-1) SHALL wrap both counters to (0,0).
REQ-018 An accepted pixel with in_sof=1 SHALL be treated as (0,0) whatever the counter values, and the counters SHALL continue from (0,1).
REQ-019 Two line buffers of depth IMG_W SHALL hold rows r-1 and r-2; a 3x3 shift window SHALL hold columns c-2..c.
REQ-020 Kernel is [1 2 1; 2 4 2; 1 2 1]: corners weight 1, edges weight 2, centre weight 4.
REQ-021 Accumulation SHALL be unsigned and DATA_W+4 bits wide, with no overflow possible.
REQ-022 Result SHALL be (sum+8)>>4 when ROUND=1 and sum>>4 when ROUND=0; the result is at most 2^DATA_W-1 by construction, so no saturation logic is needed.
REQ-023 Accepting pixel (r,c) with r>=2 and c>=2 SHALL produce one output for centre (r-1,c-1).
REQ-024 No other accept SHALL produce an output; each frame yields (IMG_H-2)*(IMG_W-2) outputs, with border pixels dropped.
REQ-025 Latency: pixel (r,c) accepted on edge k SHALL make out_valid=1 with the corresponding out_data after edge k+2 (2-stage pipeline: window/sum, then round/register).
REQ-026 out_valid SHALL be a one-cycle pulse per output while enb=1.
REQ-027 Between outputs, out_data SHALL hold its last value.
REQ-028 out_eof SHALL be 1 exactly with the output for centre (IMG_H-2, IMG_W-2), and 0 otherwise.
REQ-029 While enb=0, all registers SHALL hold: counters, line buffers, window, pipeline, out_valid, out_data and out_eof.
REQ-030 When enb returns to 1, the pipeline SHALL resume with no loss or duplication of outputs.
REQ-031 in_valid=0 cycles SHALL advance the pipeline but SHALL NOT change counters, buffers or window, and SHALL NOT produce a new output.
REQ-032 Line-buffer contents from before reset or resync SHALL never reach an output, because row and column gating ensures this.

Reset
REQ-033 reset=1 on a rising edge SHALL clear col, row, pipeline valid bits, out_valid, out_data and out_eof to 0, regardless of enb.
REQ-034 reset SHALL take priority over enb, in_valid and in_sof; a pixel presented during reset is not accepted.
REQ-035 Line-buffer RAM SHALL NOT require reset.
REQ-036 After a mid-frame reset, the next accepted pixel SHALL be treated as (0,0).

Verification (IMG_W=4, IMG_H=4, DATA_W=8)
REQ-037 Constant frame: 16 pixels of value 100 with in_valid=1 continuously -> 4 outputs of 100, each 2 cycles after inputs (2,2), (2,3), (3,2) and (3,3); out_eof=1 on the 4th output only.
REQ-038 Impulse, ROUND=1: 255 at (1,1) and 0 elsewhere -> outputs 64, 32, 32, 16. Same input with ROUND=0 -> 63, 31, 31, 15.
REQ-039 Full scale: all pixels 255, ROUND=1 -> all outputs 255 (sum 4080, plus 8, shifted right by 4), with no wrap.
REQ-040 Stall: enb=0 for 3 cycles mid-frame, then in_valid gaps of 1-2 cycles -> in_ready=0 during the stall, outputs held, and the output sequence identical to the unstalled run.
REQ-041 Reset mid-frame (after 7 pixels), then a fresh frame -> no out_valid until 2 cycles after new pixel (2,2); values match the constant-frame case.
REQ-042 Resync: in_sof=1 on the 6th pixel of a frame -> counters restart at (0,0), and exactly 4 outputs and 1 out_eof occur for the following 16 pixels.
